// File: rtl/roi_downsample_gray.sv
// ROI RGB565 stream -> 8-bit gray -> 4x4 block average into a 28x28 buffer,
// then streamed out over valid/ready once a complete image is captured.
module roi_downsample_gray #(
    parameter int unsigned ROI_DIM = 112,
    parameter int unsigned OUT_DIM = 28,
    parameter int unsigned INVERT  = 0
) (
    input  logic        pixel_clk,
    input  logic        rst_n,
    input  logic [15:0] roi_pixel,
    input  logic [6:0]  roi_x,
    input  logic [6:0]  roi_y,
    input  logic        roi_valid,
    output logic [7:0]  cnn_pixel,
    output logic [9:0]  cnn_index,
    output logic        cnn_valid,
    input  logic        cnn_ready,
    output logic        cnn_last,
    output logic        busy,
    output logic        frame_dropped
);
    localparam int unsigned DEPTH = OUT_DIM * OUT_DIM;
    localparam int unsigned AW    = 10;
    localparam int unsigned ACC_W = 12;
    localparam logic [6:0]    LAST_XY  = 7'(ROI_DIM - 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW-1:0] END_PTR  = AW'(DEPTH);
    localparam logic [7:0]    INV_MASK = (INVERT != 0) ? 8'hFF : 8'h00;

    typedef enum logic [1:0] {IDLE, CAPTURE, STREAM} state_t;

    state_t state, next_state;

    // Stage 1: RGB565 -> gray
    logic [7:0]  r8, g8, b8;
    logic [15:0] gray_full;
    logic [7:0]  s1_gray;
    logic [6:0]  s1_x, s1_y;
    logic        s1_valid;

    assign r8 = {roi_pixel[15:11], roi_pixel[15:13]};
    assign g8 = {roi_pixel[10:5],  roi_pixel[10:9]};
    assign b8 = {roi_pixel[4:0],   roi_pixel[4:2]};
    assign gray_full = 16'd77 * {8'd0, r8} + 16'd150 * {8'd0, g8} + 16'd29 * {8'd0, b8};

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_gray  <= '0;
        end else begin
            s1_valid <= roi_valid;
            s1_x     <= roi_x;
            s1_y     <= roi_y;
            s1_gray  <= 8'(gray_full >> 8);
        end
    end

    // Stage 2: block accumulation and buffer write
    logic [ACC_W-1:0] acc [OUT_DIM];
    logic [4:0]       acc_idx;
    logic [ACC_W-1:0] acc_sum;
    logic             s1_origin, blk_first, blk_done, capture_en, drop_c;
    logic [AW-1:0]    wr_addr;
    logic [7:0]       wr_data;

    assign acc_idx   = s1_x[6:2];
    assign acc_sum   = acc[acc_idx] + ACC_W'(s1_gray);
    assign s1_origin = s1_valid && (s1_x == 7'd0) && (s1_y == 7'd0);
    assign blk_first = (s1_x[1:0] == 2'd0) && (s1_y[1:0] == 2'd0);
    assign blk_done  = (s1_x[1:0] == 2'd3) && (s1_y[1:0] == 2'd3);
    assign wr_addr   = AW'(s1_y[6:2]) * AW'(OUT_DIM) + AW'(s1_x[6:2]);
    assign wr_data   = 8'(acc_sum >> 4) ^ INV_MASK;
    assign drop_c    = (state == STREAM) && s1_origin;

    // Readout: RAM read stage (a_*) feeding the output register
    logic [7:0]    mem [DEPTH];
    logic [7:0]    buf_q;
    logic [AW-1:0] rd_ptr, a_idx;
    logic          a_valid, out_load, rd_en;

    assign out_load = !cnn_valid || cnn_ready;
    assign rd_en    = (state == STREAM) && (rd_ptr != END_PTR) && (!a_valid || out_load);

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        capture_en = 1'b0;
        case (state)
            IDLE: begin
                if (s1_origin) begin
                    next_state = CAPTURE;
                    capture_en = 1'b1;
                end
            end
            CAPTURE: begin
                capture_en = s1_valid;
                if (s1_valid && s1_x == LAST_XY && s1_y == LAST_XY) next_state = STREAM;
            end
            STREAM: begin
                if (cnn_valid && cnn_ready && cnn_last) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(OUT_DIM); i++) acc[i] <= '0;
            rd_ptr        <= '0;
            a_valid       <= 1'b0;
            a_idx         <= '0;
            cnn_valid     <= 1'b0;
            cnn_pixel     <= '0;
            cnn_index     <= '0;
            cnn_last      <= 1'b0;
            busy          <= 1'b0;
            frame_dropped <= 1'b0;
        end else begin
            if (capture_en) acc[acc_idx] <= blk_first ? ACC_W'(s1_gray) : acc_sum;

            if (state != STREAM) begin
                rd_ptr    <= '0;
                a_valid   <= 1'b0;
                cnn_valid <= 1'b0;
                cnn_last  <= 1'b0;
            end else begin
                if (rd_en) begin
                    rd_ptr  <= rd_ptr + 1'b1;
                    a_valid <= 1'b1;
                    a_idx   <= rd_ptr;
                end else if (out_load) begin
                    a_valid <= 1'b0;
                end
                if (out_load) begin
                    cnn_valid <= a_valid;
                    cnn_pixel <= buf_q;
                    cnn_index <= a_idx;
                    cnn_last  <= a_valid && (a_idx == LAST_IDX);
                end
            end

            busy          <= (next_state != IDLE);
            frame_dropped <= drop_c;
        end
    end

    // Image buffer: contents survive reset
    always_ff @(posedge pixel_clk) begin
        if (capture_en && blk_done) mem[wr_addr] <= wr_data;
        if (rd_en) buf_q <= mem[rd_ptr];
    end
endmodule

// File: tb/tb_roi_downsample_gray.sv
// Randomized bench: drives full ROI frames, compares every streamed beat
// against a block-average reference image computed from the input frame.
module tb_roi_downsample_gray;
    localparam int ROI = 112;
    localparam int OD  = 28;
    localparam int NPX = ROI * ROI;
    localparam int NB  = OD * OD;

    logic        pixel_clk = 1'b0;
    logic        rst_n;
    logic [15:0] roi_pixel;
    logic [6:0]  roi_x, roi_y;
    logic        roi_valid;
    logic        cnn_ready;
    logic [7:0]  cnn_pixel, inv_pixel;
    logic [9:0]  cnn_index, inv_index;
    logic        cnn_valid, inv_valid, cnn_last, inv_last;
    logic        busy, inv_busy, frame_dropped, inv_dropped;

    int n_checks = 0;
    int n_errors = 0;
    int drop_cnt = 0;

    logic [15:0] frame_a [NPX];
    logic [15:0] frame_b [NPX];
    int          exp_img [NB];

    always #5 pixel_clk = ~pixel_clk;

    roi_downsample_gray #(.ROI_DIM(112), .OUT_DIM(28), .INVERT(0)) dut (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .roi_pixel(roi_pixel), .roi_x(roi_x),
        .roi_y(roi_y), .roi_valid(roi_valid), .cnn_pixel(cnn_pixel), .cnn_index(cnn_index),
        .cnn_valid(cnn_valid), .cnn_ready(cnn_ready), .cnn_last(cnn_last), .busy(busy),
        .frame_dropped(frame_dropped)
    );

    roi_downsample_gray #(.ROI_DIM(112), .OUT_DIM(28), .INVERT(1)) dut_inv (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .roi_pixel(roi_pixel), .roi_x(roi_x),
        .roi_y(roi_y), .roi_valid(roi_valid), .cnn_pixel(inv_pixel), .cnn_index(inv_index),
        .cnn_valid(inv_valid), .cnn_ready(cnn_ready), .cnn_last(inv_last), .busy(inv_busy),
        .frame_dropped(inv_dropped)
    );

    always @(negedge pixel_clk) if (frame_dropped) drop_cnt++;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int gray_of(input logic [15:0] p);
        int r5, g6, b5, r8, g8, b8;
        r5 = int'(p[15:11]); g6 = int'(p[10:5]); b5 = int'(p[4:0]);
        r8 = r5 * 8 + r5 / 4;
        g8 = g6 * 4 + g6 / 16;
        b8 = b5 * 8 + b5 / 4;
        return (77 * r8 + 150 * g8 + 29 * b8) / 256;
    endfunction

    // mode 0 white, 1 red, 2 mixed block-gradient/checker blocks, 3 random
    function automatic logic [15:0] pat(input int mode, input int x, input int y);
        int s;
        s = x / 4 + y / 4;
        case (mode)
            0: return 16'hFFFF;
            1: return 16'hF800;
            2: begin
                if (s % 3 == 0) return ((x + y) % 2 == 1) ? 16'hFFFF : 16'h0000;
                return {5'd0, 6'(s), 5'd0};
            end
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic build_frame(input int mode, input bit use_b);
        for (int y = 0; y < ROI; y++)
            for (int x = 0; x < ROI; x++) begin
                if (use_b) frame_b[y * ROI + x] = pat(mode, x, y);
                else       frame_a[y * ROI + x] = pat(mode, x, y);
            end
        if (!use_b) begin
            for (int by = 0; by < OD; by++)
                for (int bx = 0; bx < OD; bx++) begin
                    int sum = 0;
                    for (int dy = 0; dy < 4; dy++)
                        for (int dx = 0; dx < 4; dx++)
                            sum += gray_of(frame_a[(by * 4 + dy) * ROI + bx * 4 + dx]);
                    exp_img[by * OD + bx] = sum / 16;
                end
        end
    endtask

    task automatic send_frame(input bit use_b, input int rows);
        for (int y = 0; y < rows; y++)
            for (int x = 0; x < ROI; x++) begin
                @(negedge pixel_clk);
                roi_pixel = use_b ? frame_b[y * ROI + x] : frame_a[y * ROI + x];
                roi_x     = 7'(x);
                roi_y     = 7'(y);
                roi_valid = 1'b1;
            end
        @(negedge pixel_clk);
        roi_valid = 1'b0;
    endtask

    task automatic recv_image(input int stop_at, input bit rand_ready, input bit chk_lat);
        int beat = 0, cyc = 0, first = -1;
        bit pv = 0, pr = 0;
        int hp = 0, hi = 0, hl = 0;
        while (beat < stop_at && cyc < 20000) begin
            @(negedge pixel_clk);
            cyc++;
            if (cnn_valid && first < 0) first = cyc;
            if (pv && !pr) begin
                chk("hold_valid", int'(cnn_valid), 1);
                chk("hold_pixel", int'(cnn_pixel), hp);
                chk("hold_index", int'(cnn_index), hi);
                chk("hold_last", int'(cnn_last), hl);
            end
            cnn_ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
            if (cnn_valid && cnn_ready) begin
                chk("index", int'(cnn_index), beat);
                chk("pixel", int'(cnn_pixel), exp_img[beat]);
                chk("last", int'(cnn_last), (beat == NB - 1) ? 1 : 0);
                chk("inv_pixel", int'(inv_pixel), 255 - exp_img[beat]);
                chk("inv_valid", int'(inv_valid), 1);
                beat++;
            end
            pv = cnn_valid; pr = cnn_ready;
            hp = int'(cnn_pixel); hi = int'(cnn_index); hl = int'(cnn_last);
        end
        if (beat < stop_at) chk("stream_timeout", beat, stop_at);
        if (chk_lat) chk("first_valid_latency_ok", (first >= 1 && first <= 4) ? 1 : 0, 1);
    endtask

    task automatic expect_idle(input string tag);
        repeat (3) @(negedge pixel_clk);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_valid"}, int'(cnn_valid), 0);
    endtask

    initial begin
        int d0;
        rst_n = 1'b0; roi_pixel = '0; roi_x = '0; roi_y = '0; roi_valid = 1'b0; cnn_ready = 1'b0;
        repeat (3) @(negedge pixel_clk);
        chk("rst_valid", int'(cnn_valid), 0);
        chk("rst_pixel", int'(cnn_pixel), 0);
        chk("rst_index", int'(cnn_index), 0);
        chk("rst_last", int'(cnn_last), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_dropped", int'(frame_dropped), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge pixel_clk);

        // White frame, ready held high
        build_frame(0, 1'b0);
        send_frame(1'b0, ROI);
        recv_image(NB, 1'b0, 1'b1);
        expect_idle("white_end");

        // Gradient/checker blocks under random backpressure
        build_frame(2, 1'b0);
        send_frame(1'b0, ROI);
        recv_image(NB, 1'b1, 1'b1);
        expect_idle("grad_end");

        // Partial frame then restart, then a new frame starting mid-stream
        d0 = drop_cnt;
        build_frame(0, 1'b1);
        send_frame(1'b1, 8);
        chk("partial_busy", int'(busy), 1);
        build_frame(3, 1'b0);
        send_frame(1'b0, ROI);
        fork
            recv_image(NB, 1'b1, 1'b0);
            begin
                repeat (10) @(negedge pixel_clk);
                send_frame(1'b1, 4);
            end
        join
        chk("drop_pulses", drop_cnt - d0, 1);
        expect_idle("drop_end");

        // Reset during stream of a red frame
        build_frame(1, 1'b0);
        send_frame(1'b0, ROI);
        recv_image(300, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_valid", int'(cnn_valid), 0);
        chk("midrst_inv_valid", int'(inv_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        @(negedge pixel_clk);
        rst_n = 1'b1;
        repeat (2) @(negedge pixel_clk);

        // Fresh frame after reset
        build_frame(3, 1'b0);
        send_frame(1'b0, ROI);
        recv_image(NB, 1'b1, 1'b1);
        expect_idle("final_end");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
